// File: rtl/updown_seq_monitor.sv
// ============================================================================
//  Module   : updown_seq_monitor
//  Purpose  : Step checker for a 2-bit up/down counter. It counts step errors,
//             raises a sticky fault, and flags wrap and direction events.
//             Optional macro UDMON_WRAP_CNT_EN adds the wrap_cnt port/register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_seq_monitor #(
  parameter int ERR_W       = 8,
  parameter int FAULT_LIMIT = 3
`ifdef UDMON_WRAP_CNT_EN
  ,
  parameter int WRAP_W      = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m,
  input  logic [1:0]       q,
  input  logic             clr,
  output logic             dir,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fault,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             dir_chg
`ifdef UDMON_WRAP_CNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [7:0]       LIMIT   = 8'(FAULT_LIMIT);

  state_t           state_q, state_d;
  logic [1:0]       q_prev_q, q_prev_d;
  logic             m_prev_q, m_prev_d;
  logic             dir_q, dir_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       consec_q, consec_d;
  logic             fault_q, fault_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_dn_q, wrap_dn_d;
  logic             dir_chg_q, dir_chg_d;
  logic [1:0]       step_exp;

  assign step_exp = m_prev_q ? (q_prev_q - 2'd1) : (q_prev_q + 2'd1);

  always_comb begin
    state_d     = state_q;
    q_prev_d    = q;
    m_prev_d    = m;
    dir_d       = m;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    consec_d    = consec_q;
    fault_d     = fault_q;
    wrap_up_d   = 1'b0;
    wrap_dn_d   = 1'b0;
    dir_chg_d   = 1'b0;

    if (clr) begin
      // Clear takes precedence over any mismatch seen on this same edge.
      err_cnt_d = '0;
      consec_d  = '0;
      fault_d   = 1'b0;
      state_d   = ST_SYNC;
    end else begin
      case (state_q)
        ST_SYNC: state_d = ST_TRACK;
        ST_TRACK, ST_FAULT: begin
          dir_chg_d = (m != m_prev_q);
          if (q != step_exp) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
            if (consec_q != 8'hFF) consec_d = consec_q + 8'd1;
            if (consec_d >= LIMIT) begin
              fault_d = 1'b1;
              state_d = ST_FAULT;
            end
          end else begin
            consec_d  = '0;
            wrap_up_d = !m_prev_q && (q_prev_q == 2'd3) && (q == 2'd0);
            wrap_dn_d =  m_prev_q && (q_prev_q == 2'd0) && (q == 2'd3);
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      q_prev_q    <= 2'd0;
      m_prev_q    <= 1'b0;
      dir_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      consec_q    <= '0;
      fault_q     <= 1'b0;
      wrap_up_q   <= 1'b0;
      wrap_dn_q   <= 1'b0;
      dir_chg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_prev_q    <= q_prev_d;
      m_prev_q    <= m_prev_d;
      dir_q       <= dir_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      consec_q    <= consec_d;
      fault_q     <= fault_d;
      wrap_up_q   <= wrap_up_d;
      wrap_dn_q   <= wrap_dn_d;
      dir_chg_q   <= dir_chg_d;
    end
  end

  assign dir       = dir_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign fault     = fault_q;
  assign wrap_up   = wrap_up_q;
  assign wrap_dn   = wrap_dn_q;
  assign dir_chg   = dir_chg_q;

`ifdef UDMON_WRAP_CNT_EN
  // Wrap total survives clr; only reset zeroes it.
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_up_d || wrap_dn_d) wrap_cnt_d = wrap_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) wrap_cnt_q <= '0;
    else       wrap_cnt_q <= wrap_cnt_d;
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_updown_seq_monitor.sv
// ============================================================================
//  Module   : tb_updown_seq_monitor
//  Purpose  : Directed bench for updown_seq_monitor with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_seq_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m = 1'b0;
  logic [1:0] q = 2'd0;
  logic       clr = 1'b0;

  logic       dir, err_pulse, fault, wrap_up, wrap_dn, dir_chg;
  logic [7:0] err_cnt;
  logic       dir2, err_pulse2, fault2, wrap_up2, wrap_dn2, dir_chg2;
  logic [1:0] err_cnt2;
`ifdef UDMON_WRAP_CNT_EN
  logic [15:0] wrap_cnt, wrap_cnt2;
`endif

  updown_seq_monitor #(.ERR_W(8), .FAULT_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .m(m), .q(q), .clr(clr),
    .dir(dir), .err_pulse(err_pulse), .err_cnt(err_cnt), .fault(fault),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .dir_chg(dir_chg)
`ifdef UDMON_WRAP_CNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  updown_seq_monitor #(.ERR_W(2), .FAULT_LIMIT(3)) dut2 (
    .clk(clk), .reset(reset), .m(m), .q(q), .clr(clr),
    .dir(dir2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .fault(fault2),
    .wrap_up(wrap_up2), .wrap_dn(wrap_dn2), .dir_chg(dir_chg2)
`ifdef UDMON_WRAP_CNT_EN
    , .wrap_cnt(wrap_cnt2)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit md_synced;
  int md_qp;
  bit md_mp;
  int e_consec, e_err8, e_err2, e_wraps;
  bit e_dir, e_err_pulse, e_fault, e_wrap_up, e_wrap_dn, e_dir_chg;

  // Event tallies from the DUT, cleared per scenario
  int n_errp, n_wup, n_wdn, n_dchg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit mi, input int qi, input bit ci, input bit ri);
    int expq;
    e_err_pulse = 0; e_wrap_up = 0; e_wrap_dn = 0; e_dir_chg = 0;
    if (ri) begin
      md_synced = 0; md_qp = 0; md_mp = 0; e_dir = 0;
      e_consec = 0; e_err8 = 0; e_err2 = 0; e_wraps = 0; e_fault = 0;
    end else begin
      e_dir = mi;
      if (ci) begin
        e_err8 = 0; e_err2 = 0; e_consec = 0; e_fault = 0; md_synced = 0;
      end else if (!md_synced) begin
        md_synced = 1;
      end else begin
        expq = md_mp ? (md_qp + 3) % 4 : (md_qp + 1) % 4;
        e_dir_chg = (mi != md_mp);
        if (qi != expq) begin
          e_err_pulse = 1;
          e_err8 = (e_err8 < 255) ? e_err8 + 1 : 255;
          e_err2 = (e_err2 < 3) ? e_err2 + 1 : 3;
          e_consec++;
          if (e_consec >= 3) e_fault = 1;
        end else begin
          e_consec = 0;
          if (!md_mp && md_qp == 3 && qi == 0) e_wrap_up = 1;
          if (md_mp && md_qp == 0 && qi == 3) e_wrap_dn = 1;
          if (e_wrap_up || e_wrap_dn) e_wraps = (e_wraps + 1) % 65536;
        end
      end
      md_qp = qi; md_mp = mi;
    end
  endtask

  task automatic compare_all();
    chk("dir", 32'(dir), 32'(e_dir));
    chk("err_pulse", 32'(err_pulse), 32'(e_err_pulse));
    chk("err_cnt", 32'(err_cnt), 32'(e_err8));
    chk("fault", 32'(fault), 32'(e_fault));
    chk("wrap_up", 32'(wrap_up), 32'(e_wrap_up));
    chk("wrap_dn", 32'(wrap_dn), 32'(e_wrap_dn));
    chk("dir_chg", 32'(dir_chg), 32'(e_dir_chg));
    chk("dir_w2", 32'(dir2), 32'(e_dir));
    chk("err_pulse_w2", 32'(err_pulse2), 32'(e_err_pulse));
    chk("err_cnt_w2", 32'(err_cnt2), 32'(e_err2));
    chk("fault_w2", 32'(fault2), 32'(e_fault));
    chk("wrap_up_w2", 32'(wrap_up2), 32'(e_wrap_up));
    chk("wrap_dn_w2", 32'(wrap_dn2), 32'(e_wrap_dn));
    chk("dir_chg_w2", 32'(dir_chg2), 32'(e_dir_chg));
`ifdef UDMON_WRAP_CNT_EN
    chk("wrap_cnt", 32'(wrap_cnt), 32'(e_wraps));
    chk("wrap_cnt_w2", 32'(wrap_cnt2), 32'(e_wraps));
`endif
  endtask

  task automatic step(input bit mi, input int qi, input bit ci, input bit ri);
    m = mi; q = 2'(qi); clr = ci; reset = ri;
    model_edge(mi, qi, ci, ri);
    @(posedge clk);
    #1;
    compare_all();
    n_errp += int'(err_pulse);
    n_wup  += int'(wrap_up);
    n_wdn  += int'(wrap_dn);
    n_dchg += int'(dir_chg);
  endtask

  task automatic clear_tally();
    n_errp = 0; n_wup = 0; n_wdn = 0; n_dchg = 0;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    clear_tally();
  endtask

  initial begin
    int seq1[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int seq2q[6] = '{0, 1, 2, 1, 0, 3};
    bit seq2m[6] = '{0, 0, 1, 1, 1, 1};
    int seq3[4] = '{0, 1, 3, 0};
    int seq4[4] = '{0, 2, 0, 2};
    int seq5[6] = '{0, 2, 0, 2, 0, 2};

    // Reset state
    do_reset();
    chk("reset_outputs", {24'd0, err_cnt}
        | 32'({dir, err_pulse, fault, wrap_up, wrap_dn, dir_chg}), 32'd0);

    // Genuine up count through two wraps
    foreach (seq1[i]) step(0, seq1[i], 0, 0);
    chk("s1_wrap_up_count", 32'(n_wup), 32'd2);
    chk("s1_err_cnt", 32'(err_cnt), 32'd0);
    chk("s1_fault", 32'(fault), 32'd0);
`ifdef UDMON_WRAP_CNT_EN
    chk("s1_wrap_cnt", 32'(wrap_cnt), 32'd2);
`endif

    // Direction change then down wrap
    do_reset();
    foreach (seq2q[i]) step(seq2m[i], seq2q[i], 0, 0);
    chk("s2_dir_chg_count", 32'(n_dchg), 32'd1);
    chk("s2_wrap_dn_count", 32'(n_wdn), 32'd1);
    chk("s2_err_pulse_count", 32'(n_errp), 32'd0);
    chk("s2_dir", 32'(dir), 32'd1);

    // Single skipped value
    do_reset();
    foreach (seq3[i]) step(0, seq3[i], 0, 0);
    chk("s3_err_pulse_count", 32'(n_errp), 32'd1);
    chk("s3_err_cnt", 32'(err_cnt), 32'd1);
    chk("s3_fault", 32'(fault), 32'd0);

    // Three consecutive mismatches -> fault, then clr and re-sync
    do_reset();
    foreach (seq4[i]) begin
      step(0, seq4[i], 0, 0);
      if (i == 2) chk("s4_fault_before_limit", 32'(fault), 32'd0);
    end
    chk("s4_fault_at_limit", 32'(fault), 32'd1);
    chk("s4_err_cnt", 32'(err_cnt), 32'd3);
    step(0, 3, 1, 0);
    chk("s4_clr_fault", 32'(fault), 32'd0);
    chk("s4_clr_err_cnt", 32'(err_cnt), 32'd0);
    step(0, 1, 0, 0);
    chk("s4_sync_no_err", 32'(err_pulse), 32'd0);
    step(0, 2, 0, 0);
    chk("s4_track_match", 32'(err_pulse), 32'd0);

    // Five mismatches: narrow counter saturates, then reset mid-fault
    do_reset();
    foreach (seq5[i]) step(0, seq5[i], 0, 0);
    chk("s5_err_cnt_w2_sat", 32'(err_cnt2), 32'd3);
    chk("s5_err_cnt", 32'(err_cnt), 32'd5);
    chk("s5_fault", 32'(fault), 32'd1);
    step(1, 1, 0, 1);
    chk("s5_reset_outputs", {24'd0, err_cnt}
        | 32'({dir, err_pulse, fault, wrap_up, wrap_dn, dir_chg}), 32'd0);
`ifdef UDMON_WRAP_CNT_EN
    chk("s5_reset_wrap_cnt", 32'(wrap_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
